clock_divider_prog: RTL and testbench
=====================================

Name: clock_divider_prog

Overview:
Parametrised, runtime-programmable clock divider, successor to the fixed divide-by-4 divider. Produces a registered divided clock_out of period N input cycles, with N loadable at runtime. Also produces a one-cycle tick strobe per output period. Divisor changes take effect only at a period boundary, so clock_out never glitches. Sits next to the board clock; feeds slow-domain enables and display/scan logic.

Parameters:
CNT_W, 16, width of divisor and internal counter.
DEFAULT_DIV, 4, divisor loaded at reset; values below 2 are clamped to 2.

Ports:
clock_in  input  1  input clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset.
enable  input  1  1 = count; 0 = freeze counter and clock_out.
div_value  input  CNT_W  requested divisor N, unsigned.
div_load  input  1  single-cycle strobe; captures div_value.
clock_out  output  1  divided clock, registered.
tick  output  1  one-cycle pulse per completed output period, registered.
div_active  output  CNT_W  divisor currently in effect.
load_pending  output  1  a captured divisor is waiting for a period boundary.

Behaviour:
- One clock (clock_in), synchronous active-high reset; no other clocks or resets.
- Reset values:
  - cnt=0, clock_out=0, tick=0.
  - div_active=max(DEFAULT_DIV,2), pending register = div_active, load_pending=0.
- Clamp rule: any divisor below 2 (including 0 and 1) is treated as 2. The clamp is applied at capture.
- Counting, when enable=1:
  - cnt <= (cnt==N-1) ? 0 : cnt+1, where N=div_active.
- Waveform:
  - lo = N - floor(N/2), hi = floor(N/2).
  - Invariant: clock_out == (cnt >= lo). clock_out is registered from the next-state cnt, so the invariant holds every cycle.
  - N=4 gives 2 low / 2 high. N=5 gives 3 low / 2 high. N=2 gives 1/1.
- tick: 1 for exactly the cycle after a wrap (cnt has just become 0 via wrap). Never asserted after reset alone.
- Freeze: when enable=0, cnt, clock_out, tick(=0) and div_active hold; nothing advances.
- div_load while enable=1:
  - Clamped div_value goes to the pending register and load_pending=1.
  - At the next wrap edge, div_active <= pending and load_pending <= 0.
- div_load on the wrap edge itself: div_value is applied directly at that edge. load_pending stays 0.
- Multiple loads before a boundary: the last one wins.
- div_load while enable=0: applied immediately. div_active updates, cnt=0, clock_out=0, load_pending=0.
- Reset mid-period or with a load pending: reset wins. Pending is discarded and div_active returns to DEFAULT_DIV.
- Arithmetic is unsigned CNT_W. cnt never exceeds N-1. Wrap at N = 2^CNT_W-1 is legal.

Optional Feature:
Macro CLKDIV_PERIOD_COUNT_EN.
- Defined: adds output period_count (16 bits). It increments on every tick, wraps 0xFFFF->0, and resets to 0.
- Not defined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package clkdiv_pkg holds:
  - constant CLKDIV_MIN_DIV=2;
  - default CNT_W=16;
  - the period_count width constant (16);
  - the clamp function.
- One natural sub-module, clkdiv_load_ctrl: pending register, load_pending flag, and boundary/disabled apply logic. It outputs div_active.
- The counter and waveform logic stay in the top module.

Test Plan:
- Reset, then enable=1 with default N=4 -> clock_out pattern 0,0,1,1 repeating; tick every 4th cycle; div_active=4.
- While running, div_load with div_value=5 at cnt=1 -> load_pending=1; current period completes at N=4; next period is 3 low / 2 high; div_active=5 after the wrap.
- div_value=0 and then 1 with div_load -> div_active=2; clock_out toggles every cycle; tick every 2 cycles.
- enable=0 for 7 cycles mid-high-phase -> cnt and clock_out frozen, tick=0; enable=1 resumes from the same cnt. Then div_load 10 while disabled -> immediate div_active=10, cnt=0, clock_out=0.
- Assert reset with load_pending=1 at cnt=2 -> next cycle cnt=0, clock_out=0, load_pending=0, div_active=4.
- With CLKDIV_PERIOD_COUNT_EN, N=2, run 131072 cycles -> period_count wraps once to 0; without the macro, the bench compiles without the port.

Source files
------------

// File: rtl/clkdiv_pkg.sv
// Shared constants, load-control action encoding and the divisor clamp for the programmable clock divider.
package clkdiv_pkg;

  localparam int CLKDIV_MIN_DIV = 2;
  localparam int CLKDIV_CNT_W   = 16;
  localparam int CLKDIV_PCNT_W  = 16;

  // What the load controller does with the divisor registers on the next edge.
  typedef enum logic [1:0] {
    LD_HOLD       = 2'd0,
    LD_CAPTURE    = 2'd1,
    LD_APPLY_NEW  = 2'd2,
    LD_APPLY_PEND = 2'd3
  } ld_action_e;

  // Wide enough for any CNT_W in use; callers cast back to their own width.
  function automatic logic [63:0] clkdiv_clamp(input logic [63:0] div);
    return (div < 64'(CLKDIV_MIN_DIV)) ? 64'(CLKDIV_MIN_DIV) : div;
  endfunction

endpackage

// File: rtl/clkdiv_load_ctrl.sv
// Divisor load control: pending register, pending flag, and apply-at-boundary / apply-when-disabled logic.
module clkdiv_load_ctrl
  import clkdiv_pkg::*;
#(
  parameter int CNT_W       = CLKDIV_CNT_W,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             enable,
  input  logic             div_load,
  input  logic [CNT_W-1:0] div_value,
  input  logic             wrap,
  output logic [CNT_W-1:0] div_active,
  output logic             load_pending
);

  localparam logic [CNT_W-1:0] RESET_DIV = CNT_W'(clkdiv_clamp(64'(DEFAULT_DIV)));

  logic [CNT_W-1:0] div_clamped;
  logic [CNT_W-1:0] pending;
  ld_action_e       action;

  assign div_clamped = CNT_W'(clkdiv_clamp(64'(div_value)));

  // A load on the wrap edge itself bypasses the pending register, so the
  // flag never rises for it; a stale pending value loses to it.
  always_comb begin
    action = LD_HOLD;
    if (!enable) begin
      if (div_load) action = LD_APPLY_NEW;
    end else if (wrap) begin
      if (div_load)          action = LD_APPLY_NEW;
      else if (load_pending) action = LD_APPLY_PEND;
    end else if (div_load) begin
      action = LD_CAPTURE;
    end
  end

  always_ff @(posedge clock_in) begin
    if (reset) begin
      div_active   <= RESET_DIV;
      pending      <= RESET_DIV;
      load_pending <= 1'b0;
    end else begin
      case (action)
        LD_CAPTURE: begin
          pending      <= div_clamped;
          load_pending <= 1'b1;
        end
        LD_APPLY_NEW: begin
          div_active   <= div_clamped;
          pending      <= div_clamped;
          load_pending <= 1'b0;
        end
        LD_APPLY_PEND: begin
          div_active   <= pending;
          load_pending <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/clock_divider_prog.sv
// Runtime-programmable clock divider: registered clock_out of period N, per-period tick.
// Optional CLKDIV_PERIOD_COUNT_EN adds a 16-bit period_count output counting ticks.
module clock_divider_prog
  import clkdiv_pkg::*;
#(
  parameter int CNT_W       = CLKDIV_CNT_W,
  parameter int DEFAULT_DIV = 4
) (
  input  logic                     clock_in,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [CNT_W-1:0]         div_value,
  input  logic                     div_load,
  output logic                     clock_out,
  output logic                     tick,
`ifdef CLKDIV_PERIOD_COUNT_EN
  output logic [CLKDIV_PCNT_W-1:0] period_count,
`endif
  output logic [CNT_W-1:0]         div_active,
  output logic                     load_pending
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] lo;
  logic             wrap;

  assign wrap = enable && (cnt == div_active - CNT_W'(1));
  assign lo   = div_active - (div_active >> 1);

  always_comb begin
    cnt_next = cnt;
    if (!enable) begin
      if (div_load) cnt_next = '0;
    end else if (wrap) begin
      cnt_next = '0;
    end else begin
      cnt_next = cnt + CNT_W'(1);
    end
  end

  // clock_out follows next-state cnt so it is glitch-free and exactly (cnt >= lo).
  // Whenever div_active changes, cnt_next is 0, so the old lo gives the same answer.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      cnt       <= '0;
      clock_out <= 1'b0;
      tick      <= 1'b0;
    end else begin
      cnt       <= cnt_next;
      clock_out <= (cnt_next >= lo);
      tick      <= wrap;
    end
  end

`ifdef CLKDIV_PERIOD_COUNT_EN
  always_ff @(posedge clock_in) begin
    if (reset)     period_count <= '0;
    else if (wrap) period_count <= period_count + CLKDIV_PCNT_W'(1);
  end
`endif

  clkdiv_load_ctrl #(
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) u_load_ctrl (
    .clock_in     (clock_in),
    .reset        (reset),
    .enable       (enable),
    .div_load     (div_load),
    .div_value    (div_value),
    .wrap         (wrap),
    .div_active   (div_active),
    .load_pending (load_pending)
  );

endmodule

// File: tb/tb_clock_divider_prog.sv
// Bench for clock_divider_prog: hand-written vector table plus a cycle model feeding a scoreboard.
`timescale 1ns/1ps
module tb_clock_divider_prog;

  localparam int W = 16;

  logic         clock_in = 1'b0;
  logic         reset = 1'b1, enable = 1'b0, div_load = 1'b0;
  logic [W-1:0] div_value = '0;
  logic         clock_out, tick, load_pending;
  logic [W-1:0] div_active;
`ifdef CLKDIV_PERIOD_COUNT_EN
  logic [15:0]  period_count;
`endif

  clock_divider_prog #(.CNT_W(W), .DEFAULT_DIV(4)) dut (
    .clock_in     (clock_in),
    .reset        (reset),
    .enable       (enable),
    .div_value    (div_value),
    .div_load     (div_load),
    .clock_out    (clock_out),
    .tick         (tick),
`ifdef CLKDIV_PERIOD_COUNT_EN
    .period_count (period_count),
`endif
    .div_active   (div_active),
    .load_pending (load_pending)
  );

  always #5 clock_in = ~clock_in;

  typedef struct {
    logic         clk;
    logic         tck;
    logic [W-1:0] div;
    logic         lp;
    logic [15:0]  pc;
  } exp_t;

  typedef struct {
    logic         rst, en, ld;
    logic [W-1:0] val;
    logic         e_clk, e_tck;
    logic [W-1:0] e_div;
    logic         e_lp;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[14];
  int   checks = 0;
  int   failures = 0;

  // Reference model state, advanced once per rising edge.
  int m_cnt, m_div, m_pend, m_pc;
  bit m_lp, m_clk, m_tck;

  function automatic int clampd(input int v);
    return (v < 2) ? 2 : v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic e, input logic l, input logic [W-1:0] v);
    bit w;
    if (r) begin
      m_cnt = 0; m_clk = 0; m_tck = 0; m_div = 4; m_pend = 4; m_lp = 0; m_pc = 0;
    end else if (!e) begin
      m_tck = 0;
      if (l) begin
        m_div = clampd(int'(v)); m_pend = m_div; m_lp = 0; m_cnt = 0; m_clk = 0;
      end
    end else begin
      w = (m_cnt == m_div - 1);
      m_tck = w;
      if (w) begin
        m_cnt = 0;
        m_pc  = (m_pc + 1) % 65536;
        if (l) begin
          m_div = clampd(int'(v)); m_pend = m_div; m_lp = 0;
        end else if (m_lp) begin
          m_div = m_pend; m_lp = 0;
        end
      end else begin
        m_cnt = m_cnt + 1;
        if (l) begin
          m_pend = clampd(int'(v)); m_lp = 1;
        end
      end
      m_clk = (m_cnt >= m_div - m_div / 2);
    end
  endtask

  task automatic cycle(input logic r, input logic e, input logic l, input logic [W-1:0] v);
    exp_t x;
    reset = r; enable = e; div_load = l; div_value = v;
    @(posedge clock_in);
    model_step(r, e, l, v);
    x.clk = m_clk; x.tck = m_tck; x.div = W'(m_div); x.lp = m_lp; x.pc = 16'(m_pc);
    sb.push_back(x);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      x = sb.pop_front();
      chk("clock_out", 32'(clock_out), 32'(x.clk));
      chk("tick", 32'(tick), 32'(x.tck));
      chk("div_active", 32'(div_active), 32'(x.div));
      chk("load_pending", 32'(load_pending), 32'(x.lp));
`ifdef CLKDIV_PERIOD_COUNT_EN
      chk("period_count", 32'(period_count), 32'(x.pc));
`endif
    end
  endtask

  function automatic vec_t mkv(input logic r, e, l, input int v, input logic c, t, input int d, input logic p);
    vec_t o;
    o.rst = r; o.en = e; o.ld = l; o.val = W'(v);
    o.e_clk = c; o.e_tck = t; o.e_div = W'(d); o.e_lp = p;
    return o;
  endfunction

  // Run enabled cycles until the model sits at the given count (bounded).
  task automatic run_to_cnt(input int target, input int budget);
    int n = 0;
    while (m_cnt != target && n < budget) begin
      cycle(0, 1, 0, '0);
      n++;
    end
    chk("run_to_cnt_timeout", 32'(m_cnt), 32'(target));
  endtask

  initial begin
    // Reset, default N=4, then load 5 at cnt=1: applied only after the N=4 period ends.
    vecs[0]  = mkv(1, 0, 0, 0, 0, 0, 4, 0);
    vecs[1]  = mkv(0, 1, 0, 0, 0, 0, 4, 0);
    vecs[2]  = mkv(0, 1, 0, 0, 1, 0, 4, 0);
    vecs[3]  = mkv(0, 1, 0, 0, 1, 0, 4, 0);
    vecs[4]  = mkv(0, 1, 0, 0, 0, 1, 4, 0);
    vecs[5]  = mkv(0, 1, 0, 0, 0, 0, 4, 0);
    vecs[6]  = mkv(0, 1, 1, 5, 1, 0, 4, 1);
    vecs[7]  = mkv(0, 1, 0, 0, 1, 0, 4, 1);
    vecs[8]  = mkv(0, 1, 0, 0, 0, 1, 5, 0);
    vecs[9]  = mkv(0, 1, 0, 0, 0, 0, 5, 0);
    vecs[10] = mkv(0, 1, 0, 0, 0, 0, 5, 0);
    vecs[11] = mkv(0, 1, 0, 0, 1, 0, 5, 0);
    vecs[12] = mkv(0, 1, 0, 0, 1, 0, 5, 0);
    vecs[13] = mkv(0, 1, 0, 0, 0, 1, 5, 0);

    for (int i = 0; i < 14; i++) begin
      cycle(vecs[i].rst, vecs[i].en, vecs[i].ld, vecs[i].val);
      chk($sformatf("vec%0d_clk", i), 32'(clock_out), 32'(vecs[i].e_clk));
      chk($sformatf("vec%0d_tick", i), 32'(tick), 32'(vecs[i].e_tck));
      chk($sformatf("vec%0d_div", i), 32'(div_active), 32'(vecs[i].e_div));
      chk($sformatf("vec%0d_lp", i), 32'(load_pending), 32'(vecs[i].e_lp));
    end

    // Divisors 0 and 1 clamp to 2.
    cycle(0, 1, 1, 16'd0);
    cycle(0, 1, 1, 16'd1);
    for (int i = 0; i < 12; i++) cycle(0, 1, 0, '0);
    chk("clamp_div", 32'(div_active), 32'd2);

    // Freeze mid-high-phase at N=4, cnt=2.
    run_to_cnt(1, 4);
    cycle(0, 1, 1, 16'd4);
    run_to_cnt(2, 16);
    chk("pre_freeze_div", 32'(div_active), 32'd4);
    for (int i = 0; i < 7; i++) begin
      cycle(0, 0, 0, '0);
      chk("freeze_clk", 32'(clock_out), 32'd1);
      chk("freeze_tick", 32'(tick), 32'd0);
    end
    cycle(0, 1, 0, '0);
    cycle(0, 1, 0, '0);
    chk("resume_tick", 32'(tick), 32'd1);

    // Load while disabled applies immediately.
    cycle(0, 0, 1, 16'd10);
    chk("dis_load_div", 32'(div_active), 32'd10);
    chk("dis_load_clk", 32'(clock_out), 32'd0);
    chk("dis_load_lp", 32'(load_pending), 32'd0);
    for (int i = 0; i < 12; i++) cycle(0, 1, 0, '0);

    // Load landing exactly on the wrap edge bypasses pending.
    run_to_cnt(9, 16);
    cycle(0, 1, 1, 16'd3);
    chk("wrap_load_div", 32'(div_active), 32'd3);
    chk("wrap_load_lp", 32'(load_pending), 32'd0);
    chk("wrap_load_tick", 32'(tick), 32'd1);
    for (int i = 0; i < 8; i++) cycle(0, 1, 0, '0);

    // Last of several loads wins.
    run_to_cnt(0, 8);
    cycle(0, 1, 1, 16'd6);
    cycle(0, 1, 1, 16'd7);
    for (int i = 0; i < 12; i++) cycle(0, 1, 0, '0);
    chk("last_load_div", 32'(div_active), 32'd7);

    // Reset with a load pending at cnt=2.
    cycle(0, 0, 1, 16'd4);
    cycle(0, 1, 1, 16'd9);
    cycle(0, 1, 0, '0);
    chk("pend_before_rst", 32'(load_pending), 32'd1);
    cycle(1, 1, 0, '0);
    chk("rst_div", 32'(div_active), 32'd4);
    chk("rst_lp", 32'(load_pending), 32'd0);
    chk("rst_clk", 32'(clock_out), 32'd0);
    for (int i = 0; i < 8; i++) cycle(0, 1, 0, '0);

    // Largest divisor: full period up to and through the wrap.
    cycle(0, 0, 1, 16'hFFFF);
    chk("max_div", 32'(div_active), 32'h0000_FFFF);
    run_to_cnt(65534, 70000);
    chk("max_high", 32'(clock_out), 32'd1);
    cycle(0, 1, 0, '0);
    chk("max_wrap_tick", 32'(tick), 32'd1);
    chk("max_wrap_clk", 32'(clock_out), 32'd0);

`ifdef CLKDIV_PERIOD_COUNT_EN
    cycle(1, 0, 0, '0);
    chk("pc_reset", 32'(period_count), 32'd0);
    cycle(0, 0, 1, 16'd2);
    for (int i = 0; i < 131072; i++) cycle(0, 1, 0, '0);
    chk("pc_wrap", 32'(period_count), 32'd0);
    cycle(0, 1, 0, '0);
    cycle(0, 1, 0, '0);
    chk("pc_after_wrap", 32'(period_count), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
